// File: rtl/line_burst_seq.sv
// Line-to-word burst sequencer: expands one cache-line read or write into
// WORDS consecutive 32-bit memory transfers, one handshake per word.
module line_burst_seq #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_W-1:0]     line_addr,
  input  logic [32*WORDS-1:0]   line_wdata,
  output logic [32*WORDS-1:0]   line_rdata,
  output logic                  line_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byte_enable,
  input  logic                  mem_resp,
  input  logic [31:0]           mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a line request; only state that samples line_* inputs
  // RD    | issuing word reads, filling line_rdata word by word
  // WR    | issuing word writes from the latched line
  // DONE  | one-cycle line_resp pulse, then back to IDLE

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     base_q;
  logic [32*WORDS-1:0]   wdata_q;
  logic [32*WORDS-1:0]   rdata_q;
  logic                  line_resp_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_W-1:0]     mem_address_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_byte_enable_q;

  logic [CNT_W-1:0]      cnt_d;
  logic [ADDR_W-1:0]     base_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [31:0]           wword_d;

  // Lines are 32-byte aligned regardless of WORDS.
  assign base_d  = line_addr & ~ADDR_W'(32'd31);
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign addr_d  = base_q + (ADDR_W'(cnt_d) << 2);
  assign wword_d = wdata_q[cnt_d*32 +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      base_q            <= '0;
      wdata_q           <= '0;
      rdata_q           <= '0;
      line_resp_q       <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_wdata_q       <= '0;
      mem_byte_enable_q <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          line_resp_q <= 1'b0;
          if (line_read) begin
            state_q       <= RD;
            base_q        <= base_d;
            cnt_q         <= '0;
            mem_read_q    <= 1'b1;
            mem_address_q <= base_d;
          end else if (line_write) begin
            state_q           <= WR;
            base_q            <= base_d;
            wdata_q           <= line_wdata;
            cnt_q             <= '0;
            mem_write_q       <= 1'b1;
            mem_address_q     <= base_d;
            mem_wdata_q       <= line_wdata[31:0];
            mem_byte_enable_q <= 4'hF;
          end
        end
        RD: begin
          if (mem_resp) begin
            rdata_q[cnt_q*32 +: 32] <= mem_rdata;
            if (cnt_q == LAST) begin
              state_q       <= DONE;
              mem_read_q    <= 1'b0;
              mem_address_q <= '0;
              line_resp_q   <= 1'b1;
            end else begin
              cnt_q         <= cnt_d;
              mem_address_q <= addr_d;
            end
          end
        end
        WR: begin
          if (mem_resp) begin
            if (cnt_q == LAST) begin
              state_q           <= DONE;
              mem_write_q       <= 1'b0;
              mem_address_q     <= '0;
              mem_wdata_q       <= '0;
              mem_byte_enable_q <= 4'h0;
              line_resp_q       <= 1'b1;
            end else begin
              cnt_q         <= cnt_d;
              mem_address_q <= addr_d;
              mem_wdata_q   <= wword_d;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          line_resp_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_rdata      = rdata_q;
  assign line_resp       = line_resp_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_byte_enable_q;

endmodule

// File: tb/tb_line_burst_seq.sv
// Scoreboard bench for line_burst_seq: a memory responder with random wait
// states, a reference line model, and a monitor comparing every handshake.
module tb_line_burst_seq;
  localparam int WORDS  = 8;
  localparam int ADDR_W = 32;
  localparam int LW     = 32 * WORDS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              line_read = 1'b0;
  logic              line_write = 1'b0;
  logic [ADDR_W-1:0] line_addr = '0;
  logic [LW-1:0]     line_wdata = '0;
  logic [LW-1:0]     line_rdata;
  logic              line_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byte_enable;
  logic              mem_resp = 1'b0;
  logic [31:0]       mem_rdata = '0;

  line_burst_seq #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_addr(line_addr), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;
  typedef struct { logic rd; logic [LW-1:0] line; } lin_t;

  acc_t        exp_mem[$];
  lin_t        exp_line[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] bus_mem   [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cfg = -1;
  int          waited = 0;
  int          wait_target = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a line transaction is WORDS sequential word accesses
  // starting at the 32-byte aligned base.
  task automatic push_txn(input bit rd, input logic [31:0] addr, input logic [LW-1:0] wd);
    logic [31:0] base;
    logic [31:0] a;
    acc_t        e;
    lin_t        l;
    base   = addr & 32'hFFFF_FFE0;
    l.rd   = rd;
    l.line = '0;
    for (int k = 0; k < WORDS; k++) begin
      a      = base + 32'(4 * k);
      e.we   = !rd;
      e.addr = a;
      e.data = rd ? 32'h0 : wd[32*k +: 32];
      exp_mem.push_back(e);
      if (rd) l.line[32*k +: 32] = model_rd(a);
      else    model_mem[a] = wd[32*k +: 32];
    end
    exp_line.push_back(l);
  endtask

  // Memory responder: reacts to the registered strobes just after each edge.
  always @(posedge clk) begin
    #1;
    if (mem_read || mem_write) begin
      if (waited >= wait_target) begin
        mem_resp = 1'b1;
        if (mem_write) bus_mem[mem_address] = mem_wdata;
        mem_rdata   = mem_read ? bus_rd(mem_address) : $urandom;
        waited      = 0;
        wait_target = (wait_cfg < 0) ? $urandom_range(0, 3) : wait_cfg;
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        waited++;
      end
    end else begin
      mem_resp    = ($urandom_range(0, 3) == 0);
      mem_rdata   = $urandom;
      waited      = 0;
      wait_target = (wait_cfg < 0) ? $urandom_range(0, 3) : wait_cfg;
    end
  end

  // Monitor: compares on every presented handshake and completion pulse.
  always @(negedge clk) begin : monitor
    acc_t e;
    lin_t l;
    if (!rst) begin
      if (!mem_write) check("idle_wdata_be", {mem_wdata, mem_byte_enable}, '0);
      if ((mem_read || mem_write) && mem_resp) begin
        if (exp_mem.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_mem_access: addr 0x%0h, none expected", mem_address);
        end else begin
          e = exp_mem.pop_front();
          check("mem_write", mem_write, e.we);
          check("mem_read", mem_read, !e.we);
          check("mem_address", mem_address, e.addr);
          if (e.we) begin
            check("mem_wdata", mem_wdata, e.data);
            check("mem_byte_enable", mem_byte_enable, 4'hF);
          end
        end
      end
      if (line_resp) begin
        if (exp_line.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_line_resp: got 1, expected 0");
        end else begin
          l = exp_line.pop_front();
          if (l.rd) check("line_rdata", line_rdata, l.line);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    line_read = 1'b0;
    line_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_mem.delete();
    exp_line.delete();
    rst = 1'b0;
  endtask

  // Requester: holds the request until line_resp (or a second one if hold).
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LW-1:0] wd, input bit scramble, input bit hold,
                         output int cycles);
    int got;
    int need;
    got    = 0;
    need   = hold ? 2 : 1;
    cycles = 0;
    push_txn(rd, addr, wd);
    if (hold) push_txn(rd, addr, wd);
    line_read  = rd;
    line_write = wr;
    line_addr  = addr;
    line_wdata = wd;
    while (got < need) begin
      @(posedge clk);
      #1;
      if (got == 0) cycles++;
      if (line_resp) begin
        got++;
        if (got == need) begin
          line_read  = 1'b0;
          line_write = 1'b0;
        end
      end else if (scramble) begin
        line_addr = $urandom;
        for (int k = 0; k < WORDS; k++) line_wdata[32*k +: 32] = $urandom;
      end
      if (cycles > 400) begin
        vectors++;
        miscompares++;
        $display("FAIL txn_timeout: got %0d line_resp, expected %0d", got, need);
        do_reset();
        break;
      end
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [LW-1:0] wd;
    logic [31:0]   addr;
    int            cyc;
    bit            rd;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {line_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}, '0);
    check("rst_rdata", line_rdata, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait read of a preloaded line; also measures latency.
    for (int k = 0; k < WORDS; k++) begin
      model_mem[32'h1220 + 32'(4*k)] = 32'h1000 + 32'(k);
      bus_mem[32'h1220 + 32'(4*k)]   = 32'h1000 + 32'(k);
    end
    wait_cfg = 0;
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0, 1'b0, cyc);
    check("read_latency", cyc, 9);

    // Write with two wait cycles per word.
    wait_cfg = 2;
    for (int k = 0; k < WORDS; k++) wd[32*k +: 32] = 32'hA0 + 32'(k);
    @(posedge clk);
    #1;
    run_txn(1'b0, 1'b1, 32'h0000_2000, wd, 1'b0, 1'b0, cyc);
    wait_cfg = -1;

    // Both requests high: read wins, returns the line just written.
    run_txn(1'b1, 1'b1, 32'h0000_2008, wd, 1'b0, 1'b0, cyc);

    // Inputs scrambled mid-write, then read back.
    for (int k = 0; k < WORDS; k++) wd[32*k +: 32] = $urandom;
    run_txn(1'b0, 1'b1, 32'h0000_3011, wd, 1'b1, 1'b0, cyc);
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 1'b0, 1'b0, cyc);

    // Request held through line_resp gives back-to-back bursts.
    run_txn(1'b1, 1'b0, 32'h0000_301F, '0, 1'b0, 1'b1, cyc);

    // Reset after the third word response of a read.
    wait_cfg = 0;
    @(posedge clk);
    #1;
    push_txn(1'b1, 32'h0000_5040, '0);
    line_read = 1'b1;
    line_addr = 32'h0000_5040;
    @(posedge clk);
    #1;
    line_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midburst_rst_outputs", {line_resp, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable}, '0);
    check("midburst_rst_rdata", line_rdata, '0);
    check("midburst_words_done", exp_mem.size(), WORDS - 3);
    exp_mem.delete();
    exp_line.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cfg = -1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", {line_resp, mem_read, mem_write}, '0);
    run_txn(1'b1, 1'b0, 32'h0000_5040, '0, 1'b0, 1'b0, cyc);

    // Random mix with a small address pool so reads hit earlier writes.
    for (int t = 0; t < 30; t++) begin
      rd   = $urandom_range(0, 1);
      addr = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                         : (32'h4000 + 32'($urandom_range(0, 7) << 5) + 32'($urandom_range(0, 31)));
      for (int k = 0; k < WORDS; k++) wd[32*k +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0)
        run_txn(rd, !rd, addr, wd, 1'b0, 1'b1, cyc);
      else
        run_txn(rd, !rd, addr, wd, 1'($urandom_range(0, 1)), 1'b0, cyc);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_line_drained", exp_line.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
